// File: rtl/rom_seq_reader.sv
// Walks a run of synchronous-ROM addresses from a base address and presents each
// returned word to a downstream consumer over a valid/ready handshake.
module rom_seq_reader #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_HOLD,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  rom_addr_d  = base_addr;
                  remaining_d = count;
                  state_d     = S_WAIT;
               end else begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            state_d = abort ? S_IDLE : S_READ;
         end
         S_READ: begin
            // The ROM word is only valid during this cycle, so capture it now.
            if (abort) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end else begin
               out_data_d  = rom_data;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (abort) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               if (remaining_q == (ADDR_W+1)'(1)) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  rom_addr_d  = rom_addr_q + ADDR_W'(1);
                  remaining_d = remaining_q - (ADDR_W+1)'(1);
                  state_d     = S_WAIT;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         remaining_q <= remaining_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Self-checking bench for rom_seq_reader: directed scenarios plus random traffic,
// compared every cycle against a run-level timing/scoreboard model.
module tb_rom_seq_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] base_addr = '0;
   logic [2:0] count = '0;
   logic       abort = 1'b0;
   logic [1:0] rom_addr;
   logic [3:0] rom_data = '0;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       done;

   logic [3:0] rom_mem [4];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state: what the outputs must be in the coming cycle.
   bit         m_busy = 0, m_valid = 0, m_done = 0, m_fin = 0;
   logic [3:0] m_data = '0;
   logic [1:0] m_addr = '0;
   int         m_wait = 0;
   logic [3:0] m_q [$];

   // Observation bookkeeping for latency checks.
   bit prev_valid = 0;
   int rise_cyc = -1, done_cyc = -1, done_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   rom_seq_reader #(.ADDR_W(2), .DATA_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .count(count), .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Advance the model by one cycle given the inputs presented during it.
   task automatic model_step(input bit r, input bit s, input logic [1:0] b,
                             input logic [2:0] c, input bit ab, input bit rdy);
      m_done = 0;
      if (!r) begin
         m_busy = 0; m_valid = 0; m_data = '0; m_addr = '0; m_fin = 0; m_wait = 0;
         m_q.delete();
      end else if (!m_busy) begin
         if (s) begin
            m_busy = 1;
            if (c == 0) begin
               m_fin = 1; m_done = 1;
            end else begin
               m_addr = b;
               for (int i = 0; i < int'(c); i++) m_q.push_back(rom_mem[(int'(b) + i) % 4]);
               m_wait = 2;
            end
         end
      end else if (m_fin) begin
         m_busy = 0; m_fin = 0;
      end else if (ab) begin
         m_busy = 0; m_valid = 0; m_wait = 0;
         m_q.delete();
      end else if (m_valid) begin
         if (rdy) begin
            m_valid = 0;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               m_fin = 1; m_done = 1;
            end else begin
               m_addr = m_addr + 2'd1;
               m_wait = 2;
            end
         end
      end else if (m_wait == 1) begin
         m_valid = 1; m_data = m_q[0]; m_wait = 0;
      end else begin
         m_wait--;
      end
   endtask

   // Drive one cycle of inputs, then check the resulting outputs mid-cycle.
   task automatic tick(input bit r, input bit s, input logic [1:0] b,
                       input logic [2:0] c, input bit ab, input bit rdy);
      rst_n = r; start = s; base_addr = b; count = c; abort = ab; out_ready = rdy;
      model_step(r, s, b, c, ab, rdy);
      @(negedge clk);
      cyc++;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("done", 32'(done), 32'(m_done));
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      if (m_valid) chk("out_data", 32'(out_data), 32'(m_data));
      if (out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
      if (done) begin
         done_cyc = cyc;
         done_cnt++;
      end
      prev_valid = out_valid;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) tick(1, 0, 2'd0, 3'd0, 0, rdy);
   endtask

   initial begin
      int s0, d0;
      rom_mem[0] = 4'hA; rom_mem[1] = 4'h5; rom_mem[2] = 4'hC; rom_mem[3] = 4'h3;

      @(negedge clk);
      tick(0, 0, 2'd0, 3'd0, 0, 0);
      tick(0, 1, 2'd3, 3'd2, 1, 1);
      chk("rst_out_data", 32'(out_data), 32'h0);

      // Three words from address 0 with the consumer always ready.
      s0 = cyc; rise_cyc = -1;
      tick(1, 1, 2'd0, 3'd3, 0, 1);
      idle(12, 1);
      chk("first_valid_lat", 32'(rise_cyc - s0), 32'd3);
      chk("done_lat", 32'(done_cyc - s0), 32'd10);

      // Full-depth run wrapping through the top of the address space.
      d0 = done_cnt;
      tick(1, 1, 2'd3, 3'd4, 0, 1);
      idle(15, 1);
      chk("wrap_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Backpressure: first word stalled for five HOLD cycles.
      tick(1, 1, 2'd1, 3'd2, 0, 0);
      idle(7, 0);
      chk("bp_hold_data", 32'(out_data), 32'h5);
      idle(10, 1);

      // Empty run, then starts pulsed while a run is in progress.
      s0 = cyc;
      tick(1, 1, 2'd0, 3'd0, 0, 1);
      chk("cnt0_done_cyc", 32'(done_cyc - s0), 32'd1);
      idle(2, 1);
      tick(1, 1, 2'd0, 3'd2, 0, 1);
      for (int i = 0; i < 5; i++) tick(1, 1, 2'd3, 3'd1, 0, 1);
      idle(6, 1);

      // Abort in HOLD coinciding with a handshake.
      d0 = done_cnt;
      tick(1, 1, 2'd0, 3'd1, 0, 0);
      idle(2, 0);
      tick(1, 0, 2'd0, 3'd0, 1, 1);
      idle(4, 1);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // Reset while a word is being held, then a fresh single-word run.
      tick(1, 1, 2'd0, 3'd2, 0, 0);
      idle(3, 0);
      tick(0, 0, 2'd0, 3'd0, 0, 0);
      chk("rst_mid_data", 32'(out_data), 32'h0);
      tick(1, 1, 2'd2, 3'd1, 0, 0);
      idle(2, 0);
      chk("fresh_data", 32'(out_data), 32'hC);
      idle(4, 1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bit r, s, ab, rdy;
         r   = ($urandom_range(0, 99) != 0);
         s   = ($urandom_range(0, 4) == 0);
         ab  = ($urandom_range(0, 29) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         tick(r, s, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), ab, rdy);
      end
      idle(20, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
